// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: receiver state encoding and frame constants.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Even parity across data plus parity bit; 0 means the frame is consistent.
    function automatic logic parity_of(input logic [DATA_BITS:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is chosen
// to match the input's idle level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver into a single-entry valid/ready register, with frame/overrun flags.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_rx,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output rx_state_t            dbg_state
);

    // Output handshake: a byte is transferred on any clk edge where out_valid and
    // out_ready are both 1; out_data holds steady while out_valid=1 and out_ready=0.

    localparam int CW = $clog2(clocks_per_bit);
    localparam logic [CW-1:0] HALF_M1 = CW'(clocks_per_bit / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(clocks_per_bit - 1);

    rx_state_t              state, state_n;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   cnt_clr, shift_en, bit_inc, stop_ok, stop_bad;
    logic                   dlv, par_ok;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ser_rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

`ifdef UART_RX_PARITY_EN
    logic par_smp, par_bit, perr_pend;
    assign par_ok = ~parity_of({par_bit, shift});
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        bit_inc  = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Mid-start-bit check rejects short low glitches on an idle line.
                if (cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_clr = 1'b1;
                    par_smp = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_n = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            dlv       <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_pend <= 1'b0;
`endif
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state != DATA) bit_idx <= '0;
            else if (bit_inc)  bit_idx <= bit_idx + 3'd1;
            if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};
            dlv       <= stop_ok & par_ok;
            frame_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
            if (par_smp) par_bit <= rx_s;
            perr_pend <= stop_ok & ~par_ok;
`endif
        end
    end

    // Delivery happens one cycle after the stop sample; shift is idle until the next DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_pend;
`endif
            if (dlv) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shift;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
